avr_irq_ctrl: RTL and testbench

//  Interrupt controller downstream of the systick and other peripheral irq lines.
//  - Latches up to NIRQ request lines into pending bits and masks them per line.
//  - Presents one prioritised, vectored request to the AVR core, with a req/ack handshake.
//  - Programmed through the same 2-bit-address I/O port as the peripherals.

---
 rtl/avr_irq_ctrl_pkg.sv | 17 +
 rtl/avr_irq_ctrl_prio_enc.sv | 25 ++
 rtl/avr_irq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_avr_irq_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_irq_ctrl_pkg.sv
// Shared constants for the AVR interrupt controller: register offsets, FSM states, GIE bit.
package avr_irq_pkg;

  localparam logic [1:0] IMSK_A  = 2'd0;
  localparam logic [1:0] IPEND_A = 2'd1;
  localparam logic [1:0] IVEC_A  = 2'd2;
  localparam logic [1:0] ICTL_A  = 2'd3;

  localparam int unsigned GIE_BIT = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/avr_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: eligible vector -> {any, vector index}.
module avr_irq_prio_enc #(
  parameter int unsigned NIRQ = 8,
  parameter int unsigned VW   = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic [NIRQ-1:0] act,
  output logic            any,
  output logic [VW-1:0]   vec
);

  logic found;

  always_comb begin
    any   = |act;
    vec   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (act[i] && !found) begin
        vec   = VW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller: pending/mask registers, prioritised vectored req/ack to the core.
// Optional per-line edge detection is enabled by defining AVR_IRQ_EDGE_EN.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int unsigned NIRQ = 8,
  parameter int unsigned VW   = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [1:0]      io_a,
  input  logic [7:0]      io_di,
  output logic [7:0]      io_do,
  input  logic [NIRQ-1:0] irq_in,
  output logic            irq_req,
  output logic [VW-1:0]   irq_vec,
  input  logic            irq_ack
);

  state_e          state_q, state_d;
  logic [NIRQ-1:0] irq_s_q, irq_s_d;
  logic [NIRQ-1:0] imsk_q, imsk_d;
  logic [NIRQ-1:0] ipend_q, ipend_d;
  logic            gie_q, gie_d;
  logic [VW-1:0]   vec_q, vec_d;

  logic [NIRQ-1:0] act;
  logic [NIRQ-1:0] set_v;
  logic [NIRQ-1:0] clr_v;
  logic            any;
  logic [VW-1:0]   win;
  logic            ack_hit;

`ifdef AVR_IRQ_EDGE_EN
  logic [NIRQ-1:0] irq_s_dly_q, irq_s_dly_d;
  logic [6:0]      edge_q, edge_d;
  logic [7:0]      edge_ext;
`endif

  assign act     = ipend_q & imsk_q & {NIRQ{gie_q}};
  assign ack_hit = (state_q == S_REQ) && irq_ack;

  avr_irq_prio_enc #(
    .NIRQ (NIRQ),
    .VW   (VW)
  ) u_prio (
    .act (act),
    .any (any),
    .vec (win)
  );

  always_comb begin
    irq_s_d = irq_in;
    imsk_d  = imsk_q;
    gie_d   = gie_q;
    clr_v   = '0;
`ifdef AVR_IRQ_EDGE_EN
    irq_s_dly_d = irq_s_q;
    edge_d      = edge_q;
    // line 7 has no EDGE bit, so the extended mask keeps it level
    edge_ext    = {1'b0, edge_q};
    for (int unsigned i = 0; i < NIRQ; i++) begin
      set_v[i] = edge_ext[i] ? (irq_s_q[i] & ~irq_s_dly_q[i]) : irq_s_q[i];
    end
`else
    set_v = irq_s_q;
`endif

    if (io_we && io_a == IMSK_A)
      imsk_d = io_di[NIRQ-1:0];
    if (io_we && io_a == IPEND_A)
      clr_v = io_di[NIRQ-1:0];
    if (io_we && io_a == ICTL_A) begin
      gie_d = io_di[GIE_BIT];
`ifdef AVR_IRQ_EDGE_EN
      for (int unsigned i = 0; i < 7; i++)
        edge_d[i] = (i < NIRQ) ? io_di[i] : 1'b0;
`endif
    end
    if (ack_hit)
      clr_v[vec_q] = 1'b1;

    // set is OR'd in after the clear so a same-cycle request survives
    ipend_d = (ipend_q & ~clr_v) | set_v;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          state_d = S_REQ;
          vec_d   = win;
        end
      end
      S_REQ: begin
        if (irq_ack)
          state_d = S_GAP;
        else if (!act[vec_q])
          state_d = S_IDLE;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      irq_s_q <= '0;
      imsk_q  <= '0;
      ipend_q <= '0;
      gie_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_s_q <= irq_s_d;
      imsk_q  <= imsk_d;
      ipend_q <= ipend_d;
      gie_q   <= gie_d;
      vec_q   <= vec_d;
    end
  end

`ifdef AVR_IRQ_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_s_dly_q <= '0;
      edge_q      <= '0;
    end else begin
      irq_s_dly_q <= irq_s_dly_d;
      edge_q      <= edge_d;
    end
  end
`endif

  assign irq_req = (state_q == S_REQ);
  assign irq_vec = vec_q;

  always_comb begin
    io_do = '0;
    if (io_re) begin
      case (io_a)
        IMSK_A:  io_do[NIRQ-1:0] = imsk_q;
        IPEND_A: io_do[NIRQ-1:0] = ipend_q;
        IVEC_A: begin
          io_do[VW-1:0]    = vec_q;
          io_do[GIE_BIT]   = gie_q;
        end
        default: begin
          io_do[GIE_BIT] = gie_q;
`ifdef AVR_IRQ_EDGE_EN
          io_do[6:0]     = edge_q;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Self-checking bench for avr_irq_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_avr_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [1:0] io_a = 2'd0;
  logic [7:0] io_di = 8'h00;
  logic [7:0] io_do;
  logic [7:0] irq_in = 8'h00;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic       irq_ack = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  avr_irq_ctrl #(.NIRQ(8), .VW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_re   (io_re),
    .io_we   (io_we),
    .io_a    (io_a),
    .io_di   (io_di),
    .io_do   (io_do),
    .irq_in  (irq_in),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  // reference model state
  bit [7:0] m_sync, m_sdly, m_pend, m_mask, m_edge;
  bit       m_gie, m_req, m_gap;
  bit [2:0] m_vec;
  bit [7:0] n_sync, n_sdly, n_pend, n_mask, n_edge;
  bit       n_gie, n_req, n_gap;
  bit [2:0] n_vec;
  bit [7:0] t_act, t_set, t_clr;
  bit       t_win_ok;
  bit [2:0] t_win;

  always_comb begin
    t_act    = m_gie ? (m_pend & m_mask) : 8'h00;
    t_win_ok = 1'b0;
    t_win    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (t_act[i]) begin
        t_win    = i[2:0];
        t_win_ok = 1'b1;
      end
    end
    t_set = ((m_sync & ~m_sdly) & m_edge) | (m_sync & ~m_edge);
    t_clr = (io_we && io_a == 2'd1) ? io_di : 8'h00;
    if (m_req && irq_ack) t_clr[m_vec] = 1'b1;
    n_pend = (m_pend & ~t_clr) | t_set;
    n_mask = (io_we && io_a == 2'd0) ? io_di : m_mask;
    n_gie  = (io_we && io_a == 2'd3) ? io_di[7] : m_gie;
    n_edge = m_edge;
`ifdef AVR_IRQ_EDGE_EN
    if (io_we && io_a == 2'd3) n_edge = {1'b0, io_di[6:0]};
`endif
    n_sync = irq_in;
    n_sdly = m_sync;
    n_req  = m_req;
    n_gap  = 1'b0;
    n_vec  = m_vec;
    if (!m_gap) begin
      if (m_req) begin
        if (irq_ack) begin
          n_req = 1'b0;
          n_gap = 1'b1;
        end else if (!t_act[m_vec]) begin
          n_req = 1'b0;
        end
      end else if (t_win_ok) begin
        n_req = 1'b1;
        n_vec = t_win;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync <= '0; m_sdly <= '0; m_pend <= '0; m_mask <= '0; m_edge <= '0;
      m_gie <= 1'b0; m_req <= 1'b0; m_gap <= 1'b0; m_vec <= '0;
    end else begin
      m_sync <= n_sync; m_sdly <= n_sdly; m_pend <= n_pend; m_mask <= n_mask;
      m_edge <= n_edge; m_gie <= n_gie; m_req <= n_req; m_gap <= n_gap; m_vec <= n_vec;
    end
  end

  function automatic logic [7:0] exp_do();
    if (!io_re) return 8'h00;
    case (io_a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return {m_gie, 4'b0000, m_vec};
      default: return {m_gie, m_edge[6:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    #2;
    chk("model_irq_req", {7'b0, irq_req}, {7'b0, m_req});
    chk("model_irq_vec", {5'b0, irq_vec}, {5'b0, m_vec});
    chk("model_io_do", io_do, exp_do());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    io_we = 1'b1; io_a = a; io_di = d;
    @(negedge clk);
    io_we = 1'b0;
    #3;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    io_re = 1'b1; io_a = a;
    #3;
    chk(nm, io_do, exp);
    io_re = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input logic [2:0] v, input string nm);
    int n = 0;
    while (!irq_req && n < 20) begin
      tick(1);
      n++;
    end
    chk(nm, {7'b0, irq_req}, 8'h01);
    chk({nm, "_vec"}, {5'b0, irq_vec}, {5'b0, v});
  endtask

  task automatic do_reset();
    irq_in = 8'h00; irq_ack = 1'b0; io_we = 1'b0; io_re = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    rd(2'd0, 8'h00, "rst_imsk");
    rd(2'd1, 8'h00, "rst_ipend");
    rd(2'd2, 8'h00, "rst_ivec");
    rd(2'd3, 8'h00, "rst_ictl");
    chk("rst_req", {7'b0, irq_req}, 8'h00);
    io_a = 2'd0;
    #1 chk("do_idle", io_do, 8'h00);

    // three-cycle latency, then level re-pend after ack
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h80);
    irq_in = 8'h01;
    tick(1); chk("lat_c1", {7'b0, irq_req}, 8'h00);
    tick(1); chk("lat_c2", {7'b0, irq_req}, 8'h00);
    tick(1); chk("lat_c3", {7'b0, irq_req}, 8'h01);
    chk("lat_vec", {5'b0, irq_vec}, 8'h00);
    ack_pulse(); chk("ack_drop", {7'b0, irq_req}, 8'h00);
    tick(1);     chk("gap_low", {7'b0, irq_req}, 8'h00);
    tick(1);     chk("level_rearm", {7'b0, irq_req}, 8'h01);

    // priority and no pre-emption
    do_reset();
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h80);
    irq_in = 8'h24;
    tick(2);
    irq_in = 8'h00;
    tick(1);
    chk("prio_req", {7'b0, irq_req}, 8'h01);
    chk("prio_vec2", {5'b0, irq_vec}, 8'h02);
    ack_pulse();
    wait_req(3'd5, "prio_next5");
    irq_in = 8'h02;
    tick(4);
    chk("nopreempt_req", {7'b0, irq_req}, 8'h01);
    chk("nopreempt_vec", {5'b0, irq_vec}, 8'h05);
    irq_in = 8'h00;
    ack_pulse();
    wait_req(3'd1, "late_vec1");
    ack_pulse();

    // software W1C cancels an outstanding request
    do_reset();
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h80);
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    wait_req(3'd3, "cancel_req3");
    wr(2'd1, 8'h08);
    tick(1);
    chk("cancel_drop", {7'b0, irq_req}, 8'h00);
    rd(2'd1, 8'h00, "cancel_ipend");

    // set beats clear; GIE=0 holds off the request
    do_reset();
    irq_in = 8'h10;
    wr(2'd0, 8'h10);
    wr(2'd1, 8'h10);
    rd(2'd1, 8'h10, "setwins_ipend");
    tick(3);
    chk("gie0_noreq", {7'b0, irq_req}, 8'h00);
    rd(2'd0, 8'h10, "setwins_imsk");
    wr(2'd3, 8'h80);
    wait_req(3'd4, "gie1_req4");
    irq_in = 8'h00;
    ack_pulse();

`ifdef AVR_IRQ_EDGE_EN
    do_reset();
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h81);
    rd(2'd3, 8'h81, "edge_ictl");
    irq_in = 8'h01;
    wait_req(3'd0, "edge_first");
    ack_pulse();
    tick(8);
    chk("edge_once", {7'b0, irq_req}, 8'h00);
    rd(2'd1, 8'h00, "edge_ipend");
    irq_in = 8'h00;
    tick(2);
    irq_in = 8'h01;
    wait_req(3'd0, "edge_again");
    ack_pulse();
    irq_in = 8'h00;
`endif

    // randomized traffic against the model
    do_reset();
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h80);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 5) == 0)
        irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
      io_we = ($urandom_range(0, 11) == 0);
      io_re = ($urandom_range(0, 1) == 0);
      io_a  = 2'($urandom_range(0, 3));
      io_di = 8'($urandom);
      if (io_a == 2'd3) io_di[7] = ($urandom_range(0, 3) != 0);
      if (io_a == 2'd1) io_di = io_di & 8'($urandom);
      irq_ack = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 1'b0; io_we = 1'b0; io_re = 1'b0; irq_ack = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
